// File: rtl/posit_defines.sv
// Shared posit format parameters and the decoded-value payload.
package posit_defines;

    localparam int unsigned NBITS    = 32;
    localparam int unsigned ES       = 2;
    localparam int unsigned NREQ_MAX = 16;
    localparam int unsigned SCALE_W  = 9;
    localparam int unsigned FRAC_W   = NBITS - 3 - ES;
    localparam int unsigned RUN_W    = $clog2(NBITS);

    typedef struct packed {
        logic                      sgn;
        logic signed [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]         fraction;
        logic                      inf;
        logic                      zero;
    } value;

endpackage

// File: rtl/posit_extract.sv
// Combinational posit decoder: sign, regime+exponent scale, fraction and magnitude.
module posit_extract
    import posit_defines::*;
(
    input  logic [NBITS-1:0] posit,
    output value             val,
    output logic [NBITS-2:0] mag
);

    logic [NBITS-2:0] mag_c;
    logic [NBITS-2:0] tmp;
    logic             r0;
    logic             done;
    logic [RUN_W-1:0] run;
    logic [RUN_W:0]   sh;
    logic [ES-1:0]    ex;
    logic [FRAC_W-1:0] frac;
    int               k_i;

    always_comb begin
        mag_c = posit[NBITS-1] ? (NBITS-1)'(-posit) : posit[NBITS-2:0];
        r0    = mag_c[NBITS-2];
        run   = '0;
        done  = 1'b0;
        tmp   = mag_c;
        // Regime run length: leading bits equal to the first regime bit.
        for (int i = 0; i < int'(NBITS) - 1; i++) begin
            if (!done && tmp[NBITS-2] == r0) run = run + RUN_W'(1);
            else done = 1'b1;
            tmp = tmp << 1;
        end
        sh = {1'b0, run} + (RUN_W+1)'(1);
        // Drop regime and terminator; the two LSBs are always zero after the shift.
        {ex, frac} = (ES+FRAC_W)'((mag_c << sh) >> 2);
        k_i = r0 ? int'(run) - 1 : -int'(run);

        val          = '0;
        val.sgn      = posit[NBITS-1];
        val.scale    = SCALE_W'(k_i * (1 << ES) + int'(ex));
        val.fraction = frac;
        if (posit == '0) begin
            val      = '0;
            val.zero = 1'b1;
        end else if (posit == {1'b1, {(NBITS-1){1'b0}}}) begin
            val     = '0;
            val.inf = 1'b1;
        end
        mag = mag_c;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [N-1:0] rot;
    logic         found;
    int           off;
    int           sum;

    always_comb begin
        rot   = N'({req, req} >> ptr);
        found = 1'b0;
        off   = 0;
        for (int o = 0; o < int'(N); o++) begin
            if (!found && rot[0]) begin
                found = 1'b1;
                off   = o;
            end
            rot = rot >> 1;
        end
        sum = int'(ptr) + off;
        if (sum >= int'(N)) sum = sum - int'(N);
        grant_idx = IW'(sum);
        grant     = found ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/posit_extract_arbiter.sv
// Round-robin shared posit decoder with a two-stage valid/ready pipeline.
// Optional grant counters under `POSIT_ARB_STATS_EN.
module posit_extract_arbiter
    import posit_defines::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][NBITS-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output value                       out_value,
    output logic [NBITS-2:0]           out_abs,
    output logic [IDW-1:0]             out_id
`ifdef POSIT_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0]      grant_cnt
`endif
);

    logic [IDW-1:0]   rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             s1_valid;
    logic [NBITS-1:0] s1_data;
    logic [IDW-1:0]   s1_id;
    logic             s2_accept;
    logic             s1_adv;
    logic             s1_accept;
    logic             xfer;
    value             dec_val;
    logic [NBITS-2:0] dec_mag;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: S1 can take a new item when empty or when it advances into S2.
    always_comb begin
        s2_accept = !out_valid || out_ready;
        s1_adv    = s1_valid && s2_accept;
        s1_accept = !s1_valid || s1_adv;
        req_ready = grant & {NREQ{s1_accept && rst_n}};
        xfer      = |req_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (int'(grant_idx) == int'(NREQ) - 1) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
        end else if (s1_accept) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_data <= req_data[grant_idx];
                s1_id   <= grant_idx;
            end
        end
    end

    posit_extract u_dec (
        .posit (s1_data),
        .val   (dec_val),
        .mag   (dec_mag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_value <= '0;
            out_abs   <= '0;
            out_id    <= '0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_value <= dec_val;
            out_abs   <= dec_mag;
            out_id    <= s1_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef POSIT_ARB_STATS_EN
    // Saturating per-requester transfer counters.
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (req_ready[g] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_cnt[g] = cnt;
    end
`endif

endmodule

// File: doc/posit_extract_arbiter.md
# posit_extract_arbiter

Shares a single `posit_extract` decode unit between `NREQ` independent requesters. Each requester presents a raw posit with a valid/ready handshake; a round-robin arbiter grants one per cycle into a two-stage registered pipeline, and the decoded `value`, absolute magnitude and requester ID come out on a single valid/ready result port. It sits between the operand-fetch front-ends and the posit adder/multiplier cores.

## Interface
- `NREQ`, 4, number of requesters (1..16)
- `IDW`, `NREQ>1 ? $clog2(NREQ) : 1`, width of the requester ID
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `req_valid`  in  NREQ  per-requester operand valid
- `req_data`  in  NREQ x NBITS  raw posit per requester
- `req_ready`  out  NREQ  one-hot (or zero) acceptance
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_value`  out  `value`  decoded sgn/scale/fraction/inf/zero
- `out_abs`  out  NBITS-1  two's-complement magnitude without sign
- `out_id`  out  IDW  index of the originating requester
- `grant_cnt`  out  NREQ x 16  accepted-request counters (only with `POSIT_ARB_STATS_EN`)

## Operation
- Arbiter: combinational round-robin search starting at pointer `rr_ptr`. The first `i` with `req_valid[i]` is granted.
- `req_ready[i] = grant[i] & s1_accept`.
- `req_ready` may depend on `req_valid` of any requester. Requesters must not derive `req_valid` from `req_ready`.
- Pointer update: on a transfer from `i`, `rr_ptr <= (i+1) mod NREQ`. With no transfer, the pointer holds.
- S1 register: `s1_valid`, `s1_data`, `s1_id`. S1 drives the combinational `posit_extract`.
- S2 register: `out_valid`, `out_value`, `out_abs`, `out_id`, loaded from the `posit_extract` outputs.
- `s2_accept = !out_valid | out_ready`.
- `s1_adv = s1_valid & s2_accept`.
- `s1_accept = !s1_valid | s1_adv`.
- S2 loads on `s1_adv`. `out_valid` clears when `out_ready` is high and `s1_adv` is low.
- Special encodings (0x00000000 gives zero, 0x80000000 gives inf) pass through unchanged from the decoder. The arbiter never filters them.
- Ordering: results leave in grant order. No loss or duplication under any `out_ready` pattern.
- `NREQ=1`: the arbiter degenerates to pass-through and `out_id` is always 0.

## Timing
- Reset values: `out_valid`=0, `out_value`=all-zero, `out_abs`=0, `out_id`=0, `s1_valid`=0, `rr_ptr`=0, `grant_cnt`=0.
- While `rst_n` is low, `req_ready`=0.
- Latency: a transfer in cycle k gives `out_valid` in cycle k+2, provided no stall occurs.
- Throughput: 1 result/cycle with `out_ready` held high.
- Stall: with `out_ready` low, at most 2 items are held (S1+S2). After that, `req_ready` is all-zero.
- Simultaneous `out_ready` and a new grant with both stages full: S2 drains, S1 advances, and a new item enters S1 in the same cycle.
- Reset mid-operation: in-flight items are discarded, all registers return to reset values asynchronously, and no partial result is presented.

## Configuration
- Macro `POSIT_ARB_STATS_EN`.
- Defined:
  - `grant_cnt` port exists.
  - `grant_cnt[i]` increments on each transfer from `i` and saturates at 0xFFFF.
  - Counters clear on reset only.
- Undefined: the port and counters are absent, with identical datapath behaviour and timing.

## Structure
- `posit_defines` package: `NBITS`, `ES`, `value` struct (already present).
- Add `NREQ_MAX` = 16 to the package.
- Sub-module `rr_arbiter` (params `N`): inputs `req`, `ptr`; outputs one-hot `grant` and encoded `grant_idx`.
- `posit_extract` is instantiated once, between S1 and S2.

## Test plan
- Reset: assert `rst_n`=0 with random inputs. Expect all outputs at reset values and `req_ready`=0. Release, then idle: `out_valid` stays 0.
- Single op: `req_valid[2]`=1 with 0x48000000 in cycle 1. Expect `out_valid` in cycle 3 with `out_id`=2, sgn=0, scale=1, fraction=0, inf=0, zero=0, `out_abs`=0x48000000.
- Round-robin: all 4 requesters continuously valid, `out_ready`=1. Expect `out_id` sequence 0,1,2,3,0,1 at one result per cycle.
- Backpressure: stream from requester 0 with `out_ready` low for 5 cycles. Expect exactly 2 held items and `req_ready`=0. On release, all items are delivered in order with none dropped or duplicated.
- Specials: 0x00000000 gives zero=1. 0x80000000 gives inf=1. 0xC0000000 gives sgn=1, scale=0, `out_abs`=0x40000000.
- Mid-flight reset: pulse `rst_n` low with S1 and S2 full. Expect `out_valid`=0 immediately and `rr_ptr`=0 (next grant goes to the lowest valid index). With `POSIT_ARB_STATS_EN`, `grant_cnt` returns to 0.
